// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start detect, centre-sampled LSB-first data, stop-bit check.
// Presents the received word with a single-cycle completion pulse and a framing-error flag.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            ferr_q, ferr_d;
    logic            done_q, done_d;
    logic            rx_meta_q, rx_sync_q;

    // Next-state and datapath; everything except leaving IDLE waits for s_tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_sync_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        dout_d  = b_q;
                        ferr_d  = ~rx_sync_q;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, outputs and the 2-FF rx synchronizer (idle-high reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;

endmodule
